pipe_hazard_ctl: RTL and testbench
==================================

// Module: pipe_hazard_ctl
// PURPOSE
//  Pipeline interlock sequencer for the 4-stage CPU; sits beside the forwarding unit.
//  It covers the hazards forwarding cannot: load-use, multi-cycle data memory and taken branches.
//  It drives the stage-register enables, bubble and flush controls, and keeps stall statistics.
// PARAMETERS
//  TIMEOUT   16  max MEMWAIT cycles before abort (>=2)
//  CNT_W     16  width of stall_cnt
//  R0_ZERO   0   1: reg 0 is hardwired, dest 0 never raises a load-use hazard
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  MemRd_s      in   1      instruction in EX is a load
//  dest_s       in   4      destination register of EX instruction
//  src1_reg     in   4      ID source register 1
//  src2_reg     in   4      ID source register 2
//  imm          in   1      ID instruction uses immediate; src2_reg is not read
//  branch_taken in   1      branch resolved taken in EX this cycle
//  mem_req      in   1      EX/MEM stage issuing a data-memory access this cycle
//  mem_ack      in   1      data memory completes the access this cycle
//  stat_clr     in   1      synchronous clear of stall_cnt and timeout_err
//  pc_en        out  1      PC register load enable
//  ifid_en      out  1      IF/ID register load enable
//  ifid_flush   out  1      IF/ID loads a NOP
//  idex_bubble  out  1      ID/EX loads a NOP (control bits zeroed)
//  exwb_en      out  1      EX/WB register load enable
//  mem_busy     out  1      FSM is in MEMWAIT
//  stall_cnt    out  CNT_W  saturating count of cycles with pc_en==0 (registered)
//  timeout_err  out  1      sticky: a MEMWAIT aborted on timeout (registered)
// BEHAVIOUR
//  - States: RUN=0, LDSTALL=1, MEMWAIT=2. Encoding is fixed for bench probing.
//  - Control outputs are Mealy: combinational from state and inputs, zero latency.
//  - Reset (async): state=RUN, wd=0, stall_cnt=0, timeout_err=0.
//  - During reset, outputs take the RUN values with no hazard: pc_en=ifid_en=exwb_en=1, others 0.
//  - hazard = MemRd_s & ((dest_s==src1_reg) | (!imm & dest_s==src2_reg)) & !(R0_ZERO & dest_s==0).
//  - memstall = mem_req & !mem_ack.
//  - RUN, priority order:
//    - memstall: pc_en=ifid_en=exwb_en=0, no bubble, no flush; next=MEMWAIT, wd<=1.
//    - else branch_taken: pc_en=1, ifid_flush=1, idex_bubble=1, exwb_en=1; next=RUN.
//      The branch wins over hazard because the stalled instruction is being killed anyway.
//    - else hazard: pc_en=ifid_en=0, idex_bubble=1, exwb_en=1; next=LDSTALL.
//    - else all enables 1; next=RUN.
//  - LDSTALL (exactly one cycle): hazard is ignored because the load has advanced.
//    - memstall and branch_taken are handled exactly as in RUN, with next per RUN rules.
//    - otherwise next=RUN.
//  - MEMWAIT: mem_busy=1; pc_en=ifid_en=exwb_en=0; branch_taken and hazard ignored.
//    - mem_ack: enables follow RUN rules this cycle (branch and hazard honoured); next=RUN; wd<=0.
//    - no ack and wd==TIMEOUT-1: timeout_err<=1; next=RUN; wd<=0 (access abandoned).
//    - no ack otherwise: wd<=wd+1.
//  - wd: $clog2(TIMEOUT+1) bits, internal watchdog.
//  - mem_req is sampled only in RUN/LDSTALL; in MEMWAIT only mem_ack matters.
//  - stall_cnt:
//    - +1 every cycle pc_en==0, saturates at all-ones.
//    - stat_clr has priority over increment; stat_clr also clears timeout_err.
//    - A new timeout in the same cycle as stat_clr still sets timeout_err.
//  - Async reset mid-MEMWAIT or mid-LDSTALL: immediate return to RUN; the pending access is dropped.
//  - ifid_flush and ifid_en=0 are never asserted together.
//  - mem_busy==1 implies ifid_flush==0 and idex_bubble==0.
// TESTING
//  - Reset: assert rst mid-MEMWAIT (wd=5) -> same cycle state=RUN, pc_en=1, mem_busy=0, stall_cnt=0.
//  - Load-use: MemRd_s=1, dest_s=3, src1_reg=3 -> 1 cycle pc_en=0, idex_bubble=1.
//    - Next cycle (LDSTALL, inputs held) pc_en=1; stall_cnt=1.
//  - Immediate masking: dest_s=5, src2_reg=5, imm=1, src1_reg=2 -> no stall.
//    - Same with imm=0 -> stall.
//  - Memory wait: mem_req=1, ack after 4 cycles -> pc_en=0 for 4 cycles, mem_busy=1 for 3.
//    - RUN resumes; stall_cnt=4.
//  - Timeout: TIMEOUT=16, mem_req=1, no ack -> timeout_err=1 after the 16th stall cycle, state=RUN.
//    - stat_clr then clears timeout_err and stall_cnt.
//  - Branch vs hazard same cycle: branch_taken=1 with hazard -> ifid_flush=1, idex_bubble=1, pc_en=1.
//    - Next state RUN; stall_cnt unchanged.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// Pipeline interlock sequencer for the 4-stage CPU.
// Covers what forwarding cannot: load-use, multi-cycle data memory and taken
// branches. Control outputs are Mealy (state + inputs, zero latency); stall
// statistics are registered.
module pipe_hazard_ctl #(
    parameter int TIMEOUT = 16,   // max stall cycles of one memory access, >= 2
    parameter int CNT_W   = 16,
    parameter int R0_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRd_s,
    input  logic [3:0]       dest_s,
    input  logic [3:0]       src1_reg,
    input  logic [3:0]       src2_reg,
    input  logic             imm,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             stat_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exwb_en,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    // Encoding is fixed so the bench can probe the state directly.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_bubble;
        logic exwb_en;
        logic mem_busy;
    } ctl_t;

    localparam ctl_t CTL_GO = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                idex_bubble: 1'b0, exwb_en: 1'b1, mem_busy: 1'b0};
    localparam ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exwb_en: 1'b0, mem_busy: 1'b0};

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd, wd_nxt;
    logic            to_set;
    logic            hazard;
    logic            memstall;
    ctl_t            ctl;

    // Normal-flow control: memory stall beats branch beats load-use.
    // A taken branch wins over the hazard because the dependent instruction
    // in ID is being killed anyway.
    function automatic ctl_t run_ctl(input logic ms, input logic br, input logic hz);
        ctl_t c;
        c = CTL_GO;
        if (ms) begin
            c = CTL_FREEZE;
        end else if (br) begin
            c.ifid_flush  = 1'b1;
            c.idex_bubble = 1'b1;
        end else if (hz) begin
            c.pc_en       = 1'b0;
            c.ifid_en     = 1'b0;
            c.idex_bubble = 1'b1;
        end
        return c;
    endfunction

    // Load-use detection; src2 is not read when the instruction uses an immediate.
    always_comb begin
        hazard = MemRd_s
               & ((dest_s == src1_reg) | (~imm & (dest_s == src2_reg)))
               & ~((R0_ZERO != 0) & (dest_s == 4'd0));
        memstall = mem_req & ~mem_ack;
    end

    // Mealy control outputs and next-state / watchdog logic.
    always_comb begin
        ctl       = CTL_GO;
        state_nxt = state;
        wd_nxt    = wd;
        to_set    = 1'b0;
        if (rst) begin
            // Outputs look like an idle RUN cycle while reset is held.
            ctl       = CTL_GO;
            state_nxt = RUN;
            wd_nxt    = '0;
        end else begin
            case (state)
                RUN: begin
                    ctl = run_ctl(memstall, branch_taken, hazard);
                    if (memstall) begin
                        state_nxt = MEMWAIT;
                        wd_nxt    = WD_W'(1);
                    end else if (!branch_taken && hazard) begin
                        state_nxt = LDSTALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                LDSTALL: begin
                    // The load has moved on, so the hazard no longer applies.
                    ctl = run_ctl(memstall, branch_taken, 1'b0);
                    if (memstall) begin
                        state_nxt = MEMWAIT;
                        wd_nxt    = WD_W'(1);
                    end else begin
                        state_nxt = RUN;
                    end
                end
                MEMWAIT: begin
                    if (mem_ack) begin
                        // Access completes: the pipe moves this cycle under the
                        // normal rules. mem_req is not sampled here.
                        ctl       = run_ctl(1'b0, branch_taken, hazard);
                        state_nxt = RUN;
                        wd_nxt    = '0;
                    end else begin
                        ctl          = CTL_FREEZE;
                        ctl.mem_busy = 1'b1;
                        if (wd == WD_W'(TIMEOUT - 1)) begin
                            // Give up on the access and let the pipe run again.
                            to_set    = 1'b1;
                            state_nxt = RUN;
                            wd_nxt    = '0;
                        end else begin
                            wd_nxt = wd + WD_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                    wd_nxt    = '0;
                end
            endcase
        end
    end

    // Busy drops in the acknowledge cycle, where the pipe is already moving and
    // may be flushing; busy and flush/bubble are therefore never seen together.
    always_comb begin
        pc_en       = ctl.pc_en;
        ifid_en     = ctl.ifid_en;
        ifid_flush  = ctl.ifid_flush;
        idex_bubble = ctl.idex_bubble;
        exwb_en     = ctl.exwb_en;
        mem_busy    = ctl.mem_busy;
    end

    // FSM state and memory watchdog; a reset drops any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
        end
    end

    // Stall statistics: saturating stall-cycle count and sticky timeout flag.
    // A timeout landing in the same cycle as a clear still leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (stat_clr)
                stall_cnt <= '0;
            else if (!ctl.pc_en && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (to_set)
                timeout_err <= 1'b1;
            else if (stat_clr)
                timeout_err <= 1'b0;
        end
    end

    // Output invariants.
    a_flush_en: assert property (@(posedge clk) disable iff (rst)
                                 ifid_flush |-> ifid_en);
    a_busy_clean: assert property (@(posedge clk) disable iff (rst)
                                   mem_busy |-> (!ifid_flush && !idex_bubble));

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: table of single-cycle vectors, hand sequences for
// multi-cycle corners, then a randomized run against a behavioural model.
module tb_pipe_hazard_ctl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 6;
    localparam int R0_ZERO = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             MemRd_s = 1'b0;
    logic [3:0]       dest_s = '0, src1_reg = '0, src2_reg = '0;
    logic             imm = 1'b0, branch_taken = 1'b0;
    logic             mem_req = 1'b0, mem_ack = 1'b0, stat_clr = 1'b0;
    logic             pc_en, ifid_en, ifid_flush, idex_bubble, exwb_en, mem_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_err;
    logic [5:0]       ctl_o;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .R0_ZERO(R0_ZERO)) dut (
        .clk(clk), .rst(rst), .MemRd_s(MemRd_s), .dest_s(dest_s),
        .src1_reg(src1_reg), .src2_reg(src2_reg), .imm(imm),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .stat_clr(stat_clr), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exwb_en(exwb_en),
        .mem_busy(mem_busy), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // {pc_en, ifid_en, ifid_flush, idex_bubble, exwb_en, mem_busy}
    assign ctl_o = {pc_en, ifid_en, ifid_flush, idex_bubble, exwb_en, mem_busy};

    localparam logic [5:0] GO     = 6'b110010;
    localparam logic [5:0] FREEZE = 6'b000000;
    localparam logic [5:0] WAIT   = 6'b000001;
    localparam logic [5:0] BRANCH = 6'b111110;
    localparam logic [5:0] LDUSE  = 6'b000110;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        MemRd_s = 0; dest_s = 0; src1_reg = 0; src2_reg = 0; imm = 0;
        branch_taken = 0; mem_req = 0; mem_ack = 0; stat_clr = 0;
    endtask

    // Async reset pulse between edges; leaves the DUT in RUN with cleared stats.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        #1;
        rst = 0;
    endtask

    // Expected control word under the normal-flow rules.
    function automatic logic [5:0] rules(input bit ms, input bit br, input bit hz);
        if (ms) return FREEZE;
        if (br) return BRANCH;
        if (hz) return LDUSE;
        return GO;
    endfunction

    typedef struct {
        logic       memrd;
        logic [3:0] dest, s1, s2;
        logic       imm, br, req, ack;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Behavioural model state: waiting on memory, cycles stalled so far on the
    // current access, one-cycle load shadow, expected statistics.
    bit m_wait, m_ld, m_to;
    int m_waited, m_cnt;

    initial begin
        int pc0, busy_n, cnt_before;
        bit seen;

        vecs[0] = '{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, GO};
        vecs[1] = '{1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, LDUSE};
        vecs[2] = '{1'b1, 4'd5, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, LDUSE};
        vecs[3] = '{1'b1, 4'd5, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, GO};
        vecs[4] = '{1'b0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, GO};
        vecs[5] = '{1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, BRANCH};
        vecs[6] = '{1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, FREEZE};
        vecs[7] = '{1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, GO};
        vecs[8] = '{1'b1, 4'd7, 4'd7, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, FREEZE};
        vecs[9] = '{1'b1, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, LDUSE};

        // Reset state, with a hazard on the inputs while reset is held.
        clear_inputs();
        MemRd_s = 1; dest_s = 3; src1_reg = 3; mem_req = 1;
        #1;
        chk("rst_ctl", ctl_o, GO);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_state", 32'(dut.state), 0);
        do_reset();

        // Single-cycle vectors from RUN.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            MemRd_s = vecs[i].memrd; dest_s = vecs[i].dest; src1_reg = vecs[i].s1;
            src2_reg = vecs[i].s2; imm = vecs[i].imm; branch_taken = vecs[i].br;
            mem_req = vecs[i].req; mem_ack = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d", i), ctl_o, vecs[i].exp);
        end

        // Load-use: one bubble cycle, then LDSTALL ignores the held hazard.
        do_reset();
        MemRd_s = 1; dest_s = 3; src1_reg = 3;
        #1;
        chk("lu_pc0", pc_en, 0);
        chk("lu_bubble", idex_bubble, 1);
        @(negedge clk); #1;
        chk("lu_state", 32'(dut.state), 1);
        chk("lu_pc1", pc_en, 1);
        chk("lu_cnt", stall_cnt, 1);

        // Memory wait with ack on the fifth cycle.
        do_reset();
        pc0 = 0; busy_n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            mem_req = 1; mem_ack = (i == 4);
            #1;
            if (!pc_en) pc0++;
            if (mem_busy) busy_n++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        chk("mw_pc0_cycles", pc0, 4);
        chk("mw_busy_cycles", busy_n, 3);
        chk("mw_state", 32'(dut.state), 0);
        chk("mw_cnt", stall_cnt, 4);

        // Timeout: access never acknowledged.
        do_reset();
        mem_req = 1;
        pc0 = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i > 0) begin
                @(negedge clk);
                mem_req = 0;
            end
            #1;
            if (timeout_err) seen = 1;
            else if (!pc_en) pc0++;
        end
        chk("to_seen", seen, 1);
        chk("to_stall_cycles", pc0, TIMEOUT);
        chk("to_state", 32'(dut.state), 0);
        chk("to_cnt", stall_cnt, TIMEOUT);
        @(negedge clk);
        stat_clr = 1;
        @(negedge clk);
        stat_clr = 0;
        #1;
        chk("clr_to", timeout_err, 0);
        chk("clr_cnt", stall_cnt, 0);

        // Async reset in the middle of a memory wait.
        do_reset();
        mem_req = 1;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (dut.wd == 5) seen = 1;
        end
        chk("mr_wd5", seen, 1);
        rst = 1;
        #1;
        chk("mr_state", 32'(dut.state), 0);
        chk("mr_pc", pc_en, 1);
        chk("mr_busy", mem_busy, 0);
        chk("mr_cnt", stall_cnt, 0);
        rst = 0;

        // Branch and hazard in the same cycle.
        do_reset();
        @(negedge clk);
        cnt_before = int'(stall_cnt);
        MemRd_s = 1; dest_s = 3; src1_reg = 3; branch_taken = 1;
        #1;
        chk("bh_ctl", ctl_o, BRANCH);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("bh_state", 32'(dut.state), 0);
        chk("bh_cnt", stall_cnt, cnt_before);

        // Randomized run against the model.
        do_reset();
        m_wait = 0; m_ld = 0; m_to = 0; m_waited = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit hz, ms, quiet, abort, n_wait, n_ld;
            logic [5:0] exp;
            int exp_state;
            @(negedge clk);
            quiet        = (cyc % 600) >= 420;
            MemRd_s      = ($urandom_range(0, 1) == 1);
            dest_s       = 4'($urandom_range(0, 3));
            src1_reg     = 4'($urandom_range(0, 3));
            src2_reg     = 4'($urandom_range(0, 3));
            imm          = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
            mem_req      = ($urandom_range(0, 4) == 0);
            mem_ack      = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            stat_clr     = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                #1;
                chk("rnd_rst_ctl", ctl_o, GO);
                chk("rnd_rst_cnt", stall_cnt, 0);
                rst = 0;
                m_wait = 0; m_ld = 0; m_to = 0; m_waited = 0; m_cnt = 0;
            end
            #1;
            exp_state = m_wait ? 2 : (m_ld ? 1 : 0);
            chk("rnd_state", 32'(dut.state), exp_state);
            chk("rnd_cnt", stall_cnt, m_cnt);
            chk("rnd_to", timeout_err, m_to);

            hz = MemRd_s && ((dest_s == src1_reg) || (!imm && dest_s == src2_reg))
                 && !(R0_ZERO != 0 && dest_s == 0);
            abort = 0;
            n_wait = 0;
            n_ld = 0;
            if (m_wait) begin
                if (mem_ack) begin
                    exp = rules(0, branch_taken, hz);
                end else begin
                    exp = WAIT;
                    m_waited++;
                    if (m_waited == TIMEOUT) abort = 1;
                    else n_wait = 1;
                end
            end else begin
                ms  = mem_req && !mem_ack;
                exp = rules(ms, branch_taken, hz && !m_ld);
                if (ms) begin
                    n_wait = 1;
                    m_waited = 1;
                end
                n_ld = !ms && !branch_taken && hz && !m_ld;
            end
            chk("rnd_ctl", ctl_o, exp);

            if (stat_clr) m_cnt = 0;
            else if (!exp[5] && m_cnt < CNT_MAX) m_cnt++;
            if (abort) m_to = 1;
            else if (stat_clr) m_to = 0;
            m_wait = n_wait;
            m_ld   = n_ld;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
